secp256k1_addsub_sched: RTL and testbench

Round-robin scheduler that shares one serial modular adder and one serial modular subtractor (secp256k1 field, 32-bit-per-cycle engines) between NUM_REQ requesters. It accepts at most one operation at a time and drives the selected engine's start/operand ports. It returns the result to the issuing requester tagged with its ID. A watchdog converts a missing engine `done` into an error response. The scheduler sits between the point-arithmetic sequencers and the add/sub engine instances.

---
 rtl/secp256k1_pkg.sv | 9 +
 rtl/secp256k1_addsub_sched_if.sv | 34 +++
 rtl/secp256k1_rr_pick.sv | 19 +
 rtl/secp256k1_addsub_sched.sv | 117 +++++++++++
 tb/tb_secp256k1_addsub_sched.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/secp256k1_pkg.sv
// secp256k1_pkg: field constants, op encoding and scheduler states shared by the add/sub scheduler.
package secp256k1_pkg;
    localparam int WORD_W = 32;
    localparam int FIELD_W = 256;
    localparam logic [FIELD_W-1:0] P = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;
endpackage

// File: rtl/secp256k1_addsub_sched_if.sv
// secp256k1_addsub_sched_if: requester, response and engine signals of the add/sub scheduler.
interface secp256k1_addsub_sched_if
    import secp256k1_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) ();
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_op;
    logic [NUM_REQ*FIELD_W-1:0] req_a;
    logic [NUM_REQ*FIELD_W-1:0] req_b;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       rsp_valid;
    logic [IDW-1:0]             rsp_id;
    logic [FIELD_W-1:0]         rsp_data;
    logic                       rsp_err;
    logic                       add_start;
    logic                       sub_start;
    logic [FIELD_W-1:0]         eng_a;
    logic [FIELD_W-1:0]         eng_b;
    logic                       add_done;
    logic                       sub_done;
    logic [FIELD_W-1:0]         add_result;
    logic [FIELD_W-1:0]         sub_result;
    logic                       busy;
    modport master (
        output req_valid, req_op, req_a, req_b, add_done, sub_done, add_result, sub_result,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, add_start, sub_start, eng_a, eng_b, busy
    );
    modport slave (
        input  req_valid, req_op, req_a, req_b, add_done, sub_done, add_result, sub_result,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, add_start, sub_start, eng_a, eng_b, busy
    );
endinterface

// File: rtl/secp256k1_rr_pick.sv
// secp256k1_rr_pick: first set valid bit at or after ptr, wrapping, as one-hot grant and index.
module secp256k1_rr_pick #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   valid,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] idx
);
    always_comb begin
        idx = '0;
        // Scan from the farthest offset down so the closest one to ptr is written last.
        for (int i = N - 1; i >= 0; i--) begin
            if (valid[(int'(ptr) + i) % N]) idx = IDW'((int'(ptr) + i) % N);
        end
        grant = (valid == '0) ? '0 : ({{(N-1){1'b0}}, 1'b1} << idx);
    end
endmodule

// File: rtl/secp256k1_addsub_sched.sv
// secp256k1_addsub_sched: round-robin sharing of one serial modular adder and subtractor,
// with a watchdog that turns a missing engine done into an error response.
module secp256k1_addsub_sched
    import secp256k1_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    secp256k1_addsub_sched_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT);

    state_t             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d, id_q, id_d, win_idx;
    logic               op_q, op_d, err_q, err_d;
    logic [FIELD_W-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NUM_REQ-1:0] grant;
    logic               done;
    logic [FIELD_W-1:0] result;

    secp256k1_rr_pick #(.N(NUM_REQ), .IDW(IDW)) u_pick (
        .valid(bus.req_valid),
        .ptr  (ptr_q),
        .grant(grant),
        .idx  (win_idx)
    );

    // Only the engine that was started is listened to.
    assign done   = (op_q == OP_SUB) ? bus.sub_done : bus.add_done;
    assign result = (op_q == OP_SUB) ? bus.sub_result : bus.add_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            op_q    <= OP_ADD;
            err_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            op_q    <= op_d;
            err_q   <= err_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        op_d    = op_q;
        err_d   = err_q;
        a_d     = a_q;
        b_d     = b_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req_valid) begin
                    state_d = ST_ISSUE;
                    id_d    = win_idx;
                    op_d    = bus.req_op[win_idx];
                    a_d     = bus.req_a[win_idx * FIELD_W +: FIELD_W];
                    b_d     = bus.req_b[win_idx * FIELD_W +: FIELD_W];
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (done) begin
                    data_d  = result;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                ptr_d   = (int'(id_q) == NUM_REQ - 1) ? '0 : id_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = grant & {NUM_REQ{state_q == ST_IDLE && !rst}};
        bus.add_start = state_q == ST_ISSUE && op_q == OP_ADD;
        bus.sub_start = state_q == ST_ISSUE && op_q == OP_SUB;
        bus.rsp_valid = state_q == ST_RESP;
        bus.rsp_id    = bus.rsp_valid ? id_q : '0;
        bus.rsp_data  = bus.rsp_valid ? data_q : '0;
        bus.rsp_err   = bus.rsp_valid && err_q;
        bus.eng_a     = a_q;
        bus.eng_b     = b_q;
        bus.busy      = state_q != ST_IDLE;
    end
endmodule

// File: tb/tb_secp256k1_addsub_sched.sv
// tb_secp256k1_addsub_sched: random and directed requests against a round-robin/modular-arithmetic model,
// with a behavioural engine pair whose latency, timeout and stray-done behaviour are chosen per operation.
module tb_secp256k1_addsub_sched;
    import secp256k1_pkg::*;
    localparam int N = 4;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    secp256k1_addsub_sched_if #(.NUM_REQ(N)) bus ();
    secp256k1_addsub_sched #(.NUM_REQ(N), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {int id; logic [255:0] data; logic err; int due;} exp_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int mptr = 0;
    exp_t q[$];
    int grants[$];
    bit start_due = 0;
    logic start_op = 0;
    logic [255:0] start_a, start_b, last_data;
    logic last_err;
    int kn_lat = 0;
    bit kn_never = 0, kn_stray = 0;
    int eng_cnt = 0;
    logic eng_sub = 0;
    logic [255:0] eng_res = '0;
    bit fair_mode = 0, fair_raised = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] ref_op(input logic op, input logic [255:0] a, input logic [255:0] b);
        logic [257:0] r;
        r = op ? ({2'b0, a} + P - b) % P : ({2'b0, a} + b) % P;
        return r[255:0];
    endfunction

    function automatic int rr_model(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [255:0] rand_fe();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        case ($urandom_range(0, 7))
            0: return '0;
            1: return P - 1;
            default: return r % P;
        endcase
    endfunction

    // Engine pair: done arrives kn_lat cycles after the earliest legal cycle, never, or with a stray done on the other engine.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.add_done <= 0;
            bus.sub_done <= 0;
            bus.add_result <= '0;
            bus.sub_result <= '0;
            eng_cnt <= 0;
        end else begin
            bus.add_done <= 0;
            bus.sub_done <= 0;
            if (bus.add_start || bus.sub_start) begin
                eng_sub <= bus.sub_start;
                eng_res <= ref_op(bus.sub_start, bus.eng_a, bus.eng_b);
                eng_cnt <= (kn_never || kn_lat == 0) ? 0 : kn_lat;
                if (!kn_never && kn_lat == 0) begin
                    if (bus.sub_start) begin
                        bus.sub_done <= 1;
                        bus.sub_result <= ref_op(1'b1, bus.eng_a, bus.eng_b);
                    end else begin
                        bus.add_done <= 1;
                        bus.add_result <= ref_op(1'b0, bus.eng_a, bus.eng_b);
                    end
                end
                if (kn_stray) begin
                    if (bus.sub_start) begin
                        bus.add_done <= 1;
                        bus.add_result <= {8{$urandom}};
                    end else begin
                        bus.sub_done <= 1;
                        bus.sub_result <= {8{$urandom}};
                    end
                end
            end else if (eng_cnt == 1) begin
                eng_cnt <= 0;
                if (eng_sub) begin
                    bus.sub_done <= 1;
                    bus.sub_result <= eng_res;
                end else begin
                    bus.add_done <= 1;
                    bus.add_result <= eng_res;
                end
            end else if (eng_cnt > 1) begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    task automatic post(input int id, input logic op, input logic [255:0] a, input logic [255:0] b);
        bus.req_valid[id] = 1'b1;
        bus.req_op[id] = op;
        bus.req_a[id*256 +: 256] = a;
        bus.req_b[id*256 +: 256] = b;
    endtask

    task automatic step(input bit rnd);
        int w;
        logic [N-1:0] exp_rdy;
        logic op;
        @(negedge clk);
        check("add_start", bus.add_start, start_due && start_op == OP_ADD);
        check("sub_start", bus.sub_start, start_due && start_op == OP_SUB);
        if (start_due) begin
            check("eng_a", bus.eng_a, start_a);
            check("eng_b", bus.eng_b, start_b);
        end
        start_due = 0;
        w = (q.size() == 0) ? rr_model(bus.req_valid, mptr) : -1;
        exp_rdy = '0;
        if (w >= 0) exp_rdy[w] = 1'b1;
        check("req_ready", bus.req_ready, exp_rdy);
        check("busy", bus.busy, q.size() != 0);
        if (q.size() > 0 && cyc == q[0].due) begin
            check("rsp_valid", bus.rsp_valid, 1'b1);
            check("rsp_id", bus.rsp_id, q[0].id);
            check("rsp_data", bus.rsp_data, q[0].data);
            check("rsp_err", bus.rsp_err, q[0].err);
            last_data = bus.rsp_data;
            last_err = bus.rsp_err;
            mptr = (q[0].id + 1) % N;
            void'(q.pop_front());
        end else begin
            check("rsp_valid_idle", bus.rsp_valid, 1'b0);
        end
        if (w >= 0) begin
            if (rnd) begin
                kn_lat = $urandom_range(0, 5);
                kn_never = $urandom_range(0, 15) == 0;
                kn_stray = $urandom_range(0, 3) == 0;
            end
            op = bus.req_op[w];
            start_due = 1;
            start_op = op;
            start_a = bus.req_a[w*256 +: 256];
            start_b = bus.req_b[w*256 +: 256];
            q.push_back('{w, kn_never ? '0 : ref_op(op, start_a, start_b), kn_never,
                          kn_never ? cyc + 2 + TO : cyc + 3 + kn_lat});
            grants.push_back(w);
        end
        @(posedge clk);
        #1;
        if (w >= 0) bus.req_valid[w] = 1'b0;
        if (fair_mode && !fair_raised && grants.size() >= 2) begin
            post(1, OP_ADD, rand_fe(), rand_fe());
            fair_raised = 1;
        end
        if (rnd) begin
            for (int i = 0; i < N; i++) begin
                if (!bus.req_valid[i] && $urandom_range(0, 7) == 0) post(i, 1'($urandom_range(0, 1)), rand_fe(), rand_fe());
                else if (bus.req_valid[i] && $urandom_range(0, 49) == 0) bus.req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || bus.req_valid != '0 || start_due) && n < 800) begin
            step(0);
            n++;
        end
        check("drain_bound", n < 800, 1'b1);
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1;
        rst = 1;
        bus.req_valid = '0;
        @(negedge clk);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_rsp_data", bus.rsp_data, '0);
        check("rst_rsp_err", bus.rsp_err, 1'b0);
        check("rst_rsp_id", bus.rsp_id, '0);
        check("rst_starts", {bus.add_start, bus.sub_start}, '0);
        check("rst_eng_a", bus.eng_a, '0);
        check("rst_eng_b", bus.eng_b, '0);
        check("rst_ready", bus.req_ready, '0);
        @(posedge clk);
        #1;
        rst = 0;
        q.delete();
        mptr = 0;
        start_due = 0;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_op = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        repeat (2) @(posedge clk);
        reset_dut();

        post(1, OP_ADD, 256'd5, 256'd7);
        drain();
        check("add_5_7", last_data, 256'd12);
        check("add_5_7_err", last_err, 1'b0);

        post(0, OP_SUB, 256'd3, 256'd5);
        drain();
        check("sub_wrap", last_data, 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2D);

        post(2, OP_ADD, P - 1, 256'd2);
        drain();
        check("add_overflow", last_data, 256'd1);

        kn_lat = 4;
        kn_stray = 1;
        post(3, OP_ADD, 256'd100, 256'd23);
        drain();
        check("stray_ignored", last_data, 256'd123);
        kn_stray = 0;
        kn_lat = 0;

        kn_never = 1;
        post(1, OP_SUB, 256'd9, 256'd4);
        drain();
        check("timeout_err", last_err, 1'b1);
        check("timeout_data", last_data, '0);
        kn_never = 0;
        post(2, OP_SUB, 256'd9, 256'd4);
        drain();
        check("after_timeout", last_data, 256'd5);

        reset_dut();
        grants.delete();
        fair_mode = 1;
        kn_lat = 1;
        post(0, OP_ADD, rand_fe(), rand_fe());
        post(2, OP_SUB, rand_fe(), rand_fe());
        post(3, OP_ADD, rand_fe(), rand_fe());
        drain();
        fair_mode = 0;
        check("fair_count", grants.size(), 4);
        if (grants.size() == 4) begin
            check("fair_0", grants[0], 0);
            check("fair_1", grants[1], 2);
            check("fair_2", grants[2], 3);
            check("fair_3", grants[3], 1);
        end

        kn_never = 1;
        post(2, OP_ADD, 256'd1, 256'd1);
        repeat (6) step(0);
        reset_dut();
        kn_never = 0;
        post(1, OP_ADD, 256'd5, 256'd7);
        drain();
        check("after_reset", last_data, 256'd12);

        repeat (3000) step(1);
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
